// File: rtl/fft_frame_collector.sv
// Streaming sample collector: packs buffer_size samples into a frame for the
// combinational FFT, using two ping-pong banks so capture overlaps consumption.
module fft_frame_collector #(
    parameter int buffer_size = 32,
    parameter int sample_size = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [sample_size-1:0]             sample_in,
    input  logic                               sample_valid,
    output logic                               sample_ready,
    input  logic                               flush,
    output logic [buffer_size*sample_size-1:0] frame_out,
    output logic                               frame_valid,
    input  logic                               frame_ready,
    output logic [$clog2(buffer_size)-1:0]     fill_count
);
    localparam int IW = $clog2(buffer_size);
    localparam logic [IW-1:0] LAST_IDX = IW'(buffer_size - 1);

    logic [1:0][buffer_size-1:0][sample_size-1:0] r_bank;
    logic [1:0]    r_full;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [IW-1:0] r_wr_idx;

    logic w_accept;
    logic w_release;

    // Only sample_ready sees an input (flush) combinationally.
    assign sample_ready = !r_full[r_wr_bank] && !flush;
    assign frame_valid  = r_full[r_rd_bank];
    assign frame_out    = r_bank[r_rd_bank];
    assign fill_count   = r_wr_idx;

    assign w_accept  = sample_valid && sample_ready;
    assign w_release = frame_valid && frame_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank    <= '0;
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_idx  <= '0;
        end else begin
            if (w_accept) begin
                r_bank[r_wr_bank][r_wr_idx] <= sample_in;
                if (r_wr_idx == LAST_IDX) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                    r_wr_idx          <= '0;
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end else if (flush && !r_full[r_wr_bank]) begin
                r_wr_idx <= '0;
            end
            // Completion and release always hit different banks, so both land.
            if (w_release) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_collector.sv
// Directed bench for fft_frame_collector: reset, packing, backpressure,
// streaming, flush and mid-operation reset with hand-computed expectations.
module tb_fft_frame_collector;
    localparam int BS = 32;
    localparam int SS = 32;
    localparam int FW = BS * SS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [SS-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          flush = 1'b0;
    logic [FW-1:0] frame_out;
    logic          frame_valid;
    logic          frame_ready = 1'b0;
    logic [4:0]    fill_count;

    int vecs = 0;
    int errs = 0;

    fft_frame_collector #(.buffer_size(BS), .sample_size(SS)) dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .flush(flush), .frame_out(frame_out),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        int bad;
        bad = -1;
        vecs++;
        for (int k = BS - 1; k >= 0; k--)
            if (obs[k*SS +: SS] !== exp[k*SS +: SS]) bad = k;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s slot %0d observed=%0h expected=%0h", tag, bad,
                   obs[bad*SS +: SS], exp[bad*SS +: SS]);
        end
    endtask

    function automatic logic [FW-1:0] ramp(input int base);
        logic [FW-1:0] f;
        for (int k = 0; k < BS; k++) f[k*SS +: SS] = SS'(base + k);
        return f;
    endfunction

    // Present one sample for one clock; returns #1 after the edge.
    task automatic send(input logic [SS-1:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [FW-1:0] exp_f;

    initial begin
        // 1. Reset, asserted mid-clock
        #3 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_sample_ready", 32'(sample_ready), 32'd1);
        chk("rst_fill_count", 32'(fill_count), 32'd0);
        chk_frame("rst_frame_out", frame_out, '0);

        // 2. Packing with slot 5 = -1
        frame_ready = 1'b0;
        for (int i = 0; i < 31; i++) send((i == 5) ? '1 : SS'(i));
        chk("pack_fill_31", 32'(fill_count), 32'd31);
        chk("pack_not_valid_early", 32'(frame_valid), 32'd0);
        send(SS'(31));
        chk("pack_frame_valid", 32'(frame_valid), 32'd1);
        chk("pack_fill_0", 32'(fill_count), 32'd0);
        exp_f = ramp(0);
        exp_f[5*SS +: SS] = 32'hFFFF_FFFF;
        chk_frame("pack_frame", frame_out, exp_f);

        // 3. Backpressure: fill bank1, stall, then release
        for (int i = 32; i < 64; i++) send(SS'(i));
        chk("bp_sample_ready_low", 32'(sample_ready), 32'd0);
        chk_frame("bp_frame_stable", frame_out, exp_f);
        sample_in    = SS'(64);
        sample_valid = 1'b1;
        frame_ready  = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        chk("bp_held_not_taken", 32'(fill_count), 32'd0);
        chk("bp_valid_after_rel", 32'(frame_valid), 32'd1);
        chk("bp_ready_after_rel", 32'(sample_ready), 32'd1);
        chk_frame("bp_frame_bank1", frame_out, ramp(32));
        @(posedge clk); #1;
        sample_valid = 1'b0;
        chk("bp_held_accepted", 32'(fill_count), 32'd1);
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        chk("bp_bank1_released", 32'(frame_valid), 32'd0);
        for (int i = 65; i < 96; i++) send(SS'(i));
        chk("bp_bank0_valid", 32'(frame_valid), 32'd1);
        chk_frame("bp_bank0_frame", frame_out, ramp(64));

        // 4. Streaming with frame_ready tied high
        do_reset();
        frame_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            chk($sformatf("st_ready_%0d", i), 32'(sample_ready), 32'd1);
            send(SS'(i));
            if (i % 32 == 31) begin
                chk($sformatf("st_valid_%0d", i), 32'(frame_valid), 32'd1);
                chk_frame($sformatf("st_frame_%0d", i / 32), frame_out, ramp(i - 31));
            end else begin
                chk($sformatf("st_novalid_%0d", i), 32'(frame_valid), 32'd0);
            end
        end
        @(posedge clk); #1;
        frame_ready = 1'b0;
        chk("st_drained", 32'(frame_valid), 32'd0);

        // 5. Flush beats a simultaneous sample
        do_reset();
        for (int i = 1; i <= 10; i++) send(SS'(i));
        chk("fl_fill_10", 32'(fill_count), 32'd10);
        sample_in    = SS'(99);
        sample_valid = 1'b1;
        flush        = 1'b1;
        #1;
        chk("fl_ready_low", 32'(sample_ready), 32'd0);
        @(posedge clk); #1;
        flush        = 1'b0;
        sample_valid = 1'b0;
        chk("fl_fill_0", 32'(fill_count), 32'd0);
        chk("fl_no_frame", 32'(frame_valid), 32'd0);
        for (int i = 100; i < 132; i++) send(SS'(i));
        chk("fl_valid", 32'(frame_valid), 32'd1);
        chk_frame("fl_frame", frame_out, ramp(100));

        // 6. Reset mid-operation
        do_reset();
        for (int i = 0; i < 52; i++) send(SS'(i + 200));
        chk("mr_pre_valid", 32'(frame_valid), 32'd1);
        chk("mr_pre_fill", 32'(fill_count), 32'd20);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid_0", 32'(frame_valid), 32'd0);
        chk("mr_fill_0", 32'(fill_count), 32'd0);
        chk_frame("mr_frame_0", frame_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mr_ready", 32'(sample_ready), 32'd1);
        for (int i = 500; i < 532; i++) send(SS'(i));
        chk("mr_new_valid", 32'(frame_valid), 32'd1);
        chk_frame("mr_new_frame", frame_out, ramp(500));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/fft_frame_collector.md
# fft_frame_collector

Streaming-to-frame front end for the combinational FFT. It accepts one signed audio sample per handshake and packs `buffer_size` consecutive samples into a flat frame vector. The frame vector drives the FFT's `input_real` port directly. Two ping-pong banks let sample capture continue while the FFT consumer holds the previous frame.

## Interface
- `buffer_size`, default 32: samples per frame. Must be a power of two and ≥ 2, the same value as the downstream FFT.
- `sample_size`, default 32: bits per signed sample. Same value as the downstream FFT.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `sample_in`  in  `sample_size`: signed two's-complement sample.
- `sample_valid`  in  1: `sample_in` is valid this cycle.
- `sample_ready`  out  1: the collector can accept a sample this cycle.
- `flush`  in  1: discard the partially filled frame.
- `frame_out`  out  `buffer_size*sample_size`: packed frame. Sample k sits at bits `[k*sample_size +: sample_size]`; k = 0 is the oldest sample.
- `frame_valid`  out  1: `frame_out` holds a complete frame.
- `frame_ready`  in  1: the consumer has taken the frame; the bank is released.
- `fill_count`  out  `$clog2(buffer_size)`: samples already written into the bank being filled.

## Operation
- **State.**
  - Two banks, bank0 and bank1, each `buffer_size*sample_size` bits.
  - One full flag per bank: `full[1:0]`.
  - `wr_bank` (1 bit) and `wr_idx` (`$clog2(buffer_size)` bits) control filling.
  - `rd_bank` (1 bit) selects the bank presented to the consumer.
- **Reset.** All bank contents are 0, `full` = 0, `wr_bank` = 0, `rd_bank` = 0, `wr_idx` = 0.
- **Output decode.**
  - `sample_ready = !full[wr_bank] && !flush`.
  - `frame_valid = full[rd_bank]`.
  - `frame_out = bank[rd_bank]`.
  - `fill_count = wr_idx`.
- **Accept.** A sample is accepted when `sample_valid && sample_ready`. On accept:
  - write `sample_in` to `bank[wr_bank]` slot `wr_idx`;
  - if `wr_idx == buffer_size-1`: set `full[wr_bank]`, toggle `wr_bank`, clear `wr_idx` to 0;
  - otherwise increment `wr_idx`.
- **Release.** On `frame_valid && frame_ready`: clear `full[rd_bank]` and toggle `rd_bank`. Bank contents are not cleared.
- **Both banks full.** `sample_ready` = 0. Capture stalls until a release.
- **Simultaneous completion and release.** They always target different banks, so both take effect in the same cycle.
- **Release while stalled.** `sample_ready` rises on the cycle after the release edge. A sample presented on the release cycle itself is not accepted that cycle.
- **Flush.**
  - `wr_idx` clears to 0 and nothing is written.
  - A `sample_valid` in the same cycle is not accepted; flush wins.
  - `full` flags, `rd_bank` and the presented frame are unaffected.
  - Flush while `wr_bank` is full is a no-op.
- **Data integrity.**
  - `frame_out` is stable for as long as `frame_valid` is high without `frame_ready`.
  - Samples are stored bit-exact, with no sign extension or scaling. For example, −1 is stored as all ones.
- **Reset mid-operation.** Everything returns to the reset state asynchronously. Partial and full frames are lost.

## Timing
- **Frame latency.** `frame_valid` rises on the cycle after the edge that accepts the last sample of a frame.
- **FFT result.** The downstream FFT is combinational, so its result is valid in the same cycle as `frame_valid`.
- **Throughput.** One sample per cycle sustained with `frame_ready` tied high. A frame completes every `buffer_size` accepted samples, and `sample_ready` never drops.
- **Backpressure.** With `frame_ready` held low, exactly `2*buffer_size` samples are accepted before `sample_ready` falls.
- **Release and next frame.** After a release edge, if the other bank is full, `frame_valid` stays high and `frame_out` switches to the next frame in the next cycle.
- **Registered outputs.** All outputs derive from registers, except that `sample_ready` also depends combinationally on `flush`. There is no other combinational path from inputs to outputs.

## Test plan
1. **Reset.** Assert `rst_n` = 0 mid-clock, then release. → `frame_valid` = 0, `sample_ready` = 1, `fill_count` = 0, `frame_out` = 0.
2. **Packing.** `buffer_size` = 32. Stream samples 0..31, with sample 5 = −1, and `frame_ready` = 0.
   - The cycle after sample 31: `frame_valid` = 1.
   - Slot k = k, and slot 5 = 32'hFFFFFFFF.
   - `fill_count` = 0.
3. **Backpressure.** Continue with samples 32..63 and keep `frame_ready` = 0.
   - After sample 63: `sample_ready` = 0 and the 65th sample is held.
   - Pulse `frame_ready` for one cycle. Next cycle: `frame_out` slots hold 32..63, `frame_valid` = 1, `sample_ready` = 1.
   - The held sample is accepted into slot 0 of bank0.
4. **Streaming.** `frame_ready` = 1, feed 128 consecutive samples 0..127 every cycle.
   - `sample_ready` never low.
   - 4 frames appear, each one cycle after their last sample, holding 0..31, 32..63, 64..95 and 96..127.
5. **Flush.** Feed 10 samples, then pulse `flush` together with `sample_valid` (value 99), then feed 32 samples 100..131.
   - Sample 99 is not accepted.
   - `fill_count` = 0 after the flush.
   - The resulting frame holds 100..131 only.
6. **Reset mid-operation.** With bank0 full and bank1 at `fill_count` = 20, assert `rst_n` = 0. → Immediately `frame_valid` = 0 and `fill_count` = 0. After release, a fresh 32-sample frame is presented correctly.
